// File: rtl/spi_slave.sv
// spi_slave: SPI responder with synchronized pins, MSB-first shifting and a single-entry transmit holding register; SPI_SLAVE_MISO_TRISTATE_EN floats miso when idle
module spi_slave #(
  parameter int DWIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DWIDTH-1:0] din,
  input  logic              dvld,
  output logic              dready,
  output logic [DWIDTH-1:0] dout,
  output logic              rvld,
  output logic              busy
);
  localparam int CW = DWIDTH > 1 ? $clog2(DWIDTH) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, s_sclk, s_cs, s_mosi;
  logic lead, trail, sample, shift, start, stop, last, pend, full, accept, reload, miso_q;
  logic [CW-1:0] cnt;
  logic [DWIDTH-1:0] rx_sr, tx_sr, hold, load_val, tx_v, rx_next;
  assign s_sclk = sclk_s[SYNC_STAGES-1];
  assign s_cs = cs_s[SYNC_STAGES-1];
  assign s_mosi = mosi_s[SYNC_STAGES-1];
  assign dready = !full;
  assign busy = state_q == ACTIVE;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = busy ? miso_q : 1'bz;
`else
  assign miso = busy ? miso_q : 1'b0;
`endif
  always_comb begin
    lead = (s_sclk != cpol) && (sclk_d == cpol);
    trail = (s_sclk == cpol) && (sclk_d != cpol);
    sample = cpha ? trail : lead;
    shift = cpha ? lead : trail;
    start = (state_q == IDLE) && cs_d && !s_cs;
    stop = (state_q == ACTIVE) && !cs_d && s_cs;
    state_d = start ? ACTIVE : stop ? IDLE : state_q;
    last = cnt == CW'(DWIDTH - 1);
    load_val = full ? hold : '0;
    tx_v = pend ? load_val : cpha ? tx_sr : tx_sr << 1;
    rx_next = {rx_sr[DWIDTH-2:0], s_mosi};
    reload = start || ((state_q == ACTIVE) && !stop && shift && pend);
    accept = dvld && !full;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      cs_s <= '0;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b0;
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      hold <= '0;
      full <= 1'b0;
      pend <= 1'b0;
      miso_q <= 1'b0;
      dout <= '0;
      rvld <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s <= {cs_s[SYNC_STAGES-2:0], cs};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sclk_d <= s_sclk;
      cs_d <= s_cs;
      rvld <= 1'b0;
      if (start) begin
        cnt <= '0;
        tx_sr <= load_val;
        miso_q <= cpha ? 1'b0 : load_val[DWIDTH-1];
        pend <= 1'b0;
      end else if (stop) begin
        cnt <= '0;
        rx_sr <= '0;
        miso_q <= 1'b0;
        pend <= 1'b0;
      end else if (state_q == ACTIVE) begin
        if (sample) begin
          rx_sr <= rx_next;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            dout <= rx_next;
            rvld <= 1'b1;
            pend <= 1'b1;
          end
        end
        if (shift) begin
          tx_sr <= cpha ? tx_v << 1 : tx_v;
          miso_q <= tx_v[DWIDTH-1];
          pend <= 1'b0;
        end
      end
      if (accept) hold <= din;
      full <= (full && !reload) || accept;
    end
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

Synthesizable SPI slave, the responder end of the team's `spi_master`. It takes `sclk`, `mosi` and `cs` as asynchronous inputs and resynchronizes them into the system `clk` domain. It shifts received bits into a parallel word and drives `miso` from a single-entry transmit holding register. The block sits behind a pin-level SPI interface and feeds a user-side parallel data port.

## Interface
- `DWIDTH`, 8: word width in bits, MSB first.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers (minimum 2).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI serial clock from master, asynchronous.
- `cs` in 1: chip select, active low, asynchronous.
- `mosi` in 1: master-out slave-in, asynchronous.
- `miso` out 1: master-in slave-out.
- `cpol` in 1: clock polarity; must match master, static while `cs` is low.
- `cpha` in 1: clock phase; must match master, static while `cs` is low.
- `din` in DWIDTH: transmit word.
- `dvld` in 1: `din` valid; the word is accepted on a cycle where `dvld & dready`.
- `dready` out 1: holding register empty.
- `dout` out DWIDTH: last fully received word; held until the next word completes.
- `rvld` out 1: one-cycle pulse when `dout` updates.
- `busy` out 1: frame active (synchronized `cs` low).

## Operation
- **Synchronization:** `sclk`, `cs` and `mosi` each pass through `SYNC_STAGES` flops. A further register on synced `sclk` and synced `cs` provides edge detection.
- **Edge definitions:**
  - Leading edge: synced `sclk` leaves `cpol`.
  - Trailing edge: synced `sclk` returns to `cpol`.
- **Sample and shift by `cpha`:**
  - `cpha`=0: sample `mosi` on the leading edge; shift `miso` on the trailing edge.
  - `cpha`=1: shift on the leading edge; sample on the trailing edge.
- **State machine:**
  - IDLE → ACTIVE on the synced `cs` falling edge.
    - Bit counter is set to 0.
    - Transmit shift register loads from the holding register if it is full, otherwise from all-zeros. The holding register is then empty.
    - For `cpha`=0, `miso` = the loaded MSB in the same cycle.
  - In ACTIVE, each sample edge shifts `mosi` into the receive shift register LSB and increments the bit counter.
  - When the counter reaches DWIDTH (counter wraps to 0):
    - `dout` ← the receive shift register with the new bit included.
    - `rvld` pulses.
  - ACTIVE → IDLE on the synced `cs` rising edge.
    - A partial word is discarded: no `rvld`, `dout` unchanged.
    - The counter is cleared.
    - `miso` returns to its idle value.
- **Back-to-back words within one `cs`:**
  - At each word boundary the transmit shift register reloads from the holding register (zeros if empty), and the holding register is then empty.
  - `cpha`=0: the reload happens on the trailing edge after the last sample, and the new MSB is driven immediately.
  - `cpha`=1: the reload happens on the first leading edge of the next word, which drives the MSB.
- **Holding register:** `dready` = holding register empty. `dvld` while `dready`=0 is ignored; the register contents are kept.
- **Simultaneous accept and reload in the same cycle:** the reload takes the old holding register contents, the new `din` is stored, and `dready` stays 0.
- **Reset mid-frame:** all state returns to reset values. The block stays in IDLE until the next synced `cs` falling edge, even if `cs` is already low.

## Timing
- **Reset values:**
  - `miso`=0 (Z with the macro).
  - `dout`=0, `rvld`=0, `busy`=0, `dready`=1.
  - Shift registers and counter = 0.
- **Input latency:** SYNC_STAGES+1 `clk` cycles from a pin transition to the detected edge.
- **`rvld`:** asserted in the cycle after the detected final sample edge.
- **`miso`:** updates in the cycle after the detected shift edge, i.e. SYNC_STAGES+2 `clk` cycles after the pin edge.
- **Clock ratio requirement:** `sclk` high and low phases each ≥ SYNC_STAGES+3 `clk` periods, so `miso` settles before the master's next sample. For the default configuration, `sclk` period ≥ 10 `clk` periods.
- **`cs` setup:** `cs` falling to the first `sclk` edge ≥ SYNC_STAGES+3 `clk` periods.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN`:
  - Defined: `miso` is 1'bz whenever `busy`=0, including in reset, so multiple slaves can share the line.
  - Undefined: `miso` is driven 0 when `busy`=0.
  - Behaviour while `busy`=1 is identical in both builds.

## Test plan
- **Mode 0, single word:** `cpol`=0, `cpha`=0, `din`=0x3C loaded before `cs` falls; master sends 0xA5 → master receives 0x3C; `dout`=0xA5 with a single `rvld` pulse; `dready`=1 after `cs` falls.
- **Mode 3, single word:** `cpol`=1, `cpha`=1, `din`=0xF0; master sends 0x0F → master gets 0xF0; `dout`=0x0F.
- **Back-to-back words:** mode 1, `din`=0x11 then 0x22 loaded when `dready`; one `cs` frame of 16 bits, master sends 0x81, 0x7E → two `rvld` pulses with `dout` 0x81 then 0x7E; master gets 0x11, 0x22.
- **Aborted frame:** `cs` rises after 4 bits → no `rvld`; `dout` keeps its prior value; the next full frame (0x5A) is received correctly.
- **Holding register full:** `dvld` with 0x99 while the holding register holds 0x33 → 0x33 is transmitted and 0x99 is dropped. With no load at all, the master receives 0x00.
- **Reset mid-frame:** `rst` pulsed after 3 bits → all outputs at reset values. No `rvld` until a fresh `cs` falling edge; the subsequent frame with 0xC3 completes correctly.
